// File: rtl/fetch1_pc_gen_if.sv
// Fetch-1 PC generator bus: redirects, BTB/predictor slots, I-cache miss handshake, PC out.
// master = PC generator side, slave = surrounding front-end.
interface fetch1_pc_gen_if #(
  parameter int PC_W      = 32,
  parameter int FETCH_W   = 4,
  parameter int RAS_DEPTH = 8
);
  localparam int RP_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  logic                             stall_i;
  logic                             commit_redirect_i;
  logic [PC_W-1:0]                  commit_pc_i;
  logic                             excp_i;
  logic [PC_W-1:0]                  excp_pc_i;
  logic                             recover_ex_i;
  logic [PC_W-1:0]                  target_ex_i;
  logic [RP_W-1:0]                  recover_ex_ckpt_i;
  logic                             recover_id_i;
  logic [PC_W-1:0]                  target_id_i;
  logic [RP_W-1:0]                  recover_id_ckpt_i;
  logic                             call_id_i;
  logic [PC_W-1:0]                  call_pc_id_i;
  logic                             rtr_id_i;
  logic [FETCH_W-1:0]               btb_hit_i;
  logic [FETCH_W-1:0][1:0]          btb_type_i;
  logic [FETCH_W-1:0][PC_W-1:0]     btb_target_i;
  logic [FETCH_W-1:0]               pred_i;
  logic                             icache_miss_i;
  logic                             fill_done_i;
  logic [PC_W-1:0]                  pc_o;
  logic                             valid_o;
  logic [FETCH_W-1:0]               slot_mask_o;
  logic [RP_W-1:0]                  ras_ckpt_o;
  logic                             miss_req_o;
  logic [PC_W-1:0]                  miss_addr_o;

  modport master (
    input  stall_i, commit_redirect_i, commit_pc_i, excp_i, excp_pc_i,
           recover_ex_i, target_ex_i, recover_ex_ckpt_i,
           recover_id_i, target_id_i, recover_id_ckpt_i,
           call_id_i, call_pc_id_i, rtr_id_i,
           btb_hit_i, btb_type_i, btb_target_i, pred_i,
           icache_miss_i, fill_done_i,
    output pc_o, valid_o, slot_mask_o, ras_ckpt_o, miss_req_o, miss_addr_o
  );

  modport slave (
    output stall_i, commit_redirect_i, commit_pc_i, excp_i, excp_pc_i,
           recover_ex_i, target_ex_i, recover_ex_ckpt_i,
           recover_id_i, target_id_i, recover_id_ckpt_i,
           call_id_i, call_pc_id_i, rtr_id_i,
           btb_hit_i, btb_type_i, btb_target_i, pred_i,
           icache_miss_i, fill_done_i,
    input  pc_o, valid_o, slot_mask_o, ras_ckpt_o, miss_req_o, miss_addr_o
  );
endinterface

// File: rtl/fetch1_pc_gen.sv
// Fetch-1 PC generator: next-PC priority select over BTB slots, checkpointed RAS,
// and an I-cache miss request/replay FSM.
module fetch1_slot_dec (
  input  logic       hit_i,
  input  logic [1:0] type_i,
  input  logic       pred_i,
  output logic       taken_o
);
  assign taken_o = hit_i && ((type_i != 2'b11) || pred_i);
endmodule

module fetch1_pc_gen #(
  parameter int              PC_W       = 32,
  parameter int              FETCH_W    = 4,
  parameter int              INST_BYTES = 8,
  parameter int              RAS_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input logic             clk,
  input logic             reset,
  fetch1_pc_gen_if.master bus
);
  localparam int RP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int SEL_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam logic [PC_W-1:0] STRIDE = PC_W'(FETCH_W * INST_BYTES);

  typedef enum logic [1:0] {RUN, MISS_REQ, MISS_WAIT} state_e;

  state_e                          state_q, state_d;
  logic [PC_W-1:0]                 pc_q, pc_d;
  logic [PC_W-1:0]                 miss_addr_q, miss_addr_d;
  logic [RP_W-1:0]                 ptr_q, ptr_d;
  logic [RAS_DEPTH-1:0][PC_W-1:0]  ras_q, ras_d;

  logic [FETCH_W-1:0] taken;
  logic [SEL_W-1:0]   sel;
  logic               any_taken;
  logic               redirect_hi;
  logic               front_ok;
  logic [1:0]         sel_type;
  logic [PC_W-1:0]    ret_addr;

  for (genvar g = 0; g < FETCH_W; g++) begin : g_slot
    fetch1_slot_dec u_dec (
      .hit_i   (bus.btb_hit_i[g]),
      .type_i  (bus.btb_type_i[g]),
      .pred_i  (bus.pred_i[g]),
      .taken_o (taken[g])
    );
  end

  // Lowest taken slot wins; mask keeps slots up to and including it.
  always_comb begin
    sel       = '0;
    any_taken = 1'b0;
    for (int i = FETCH_W - 1; i >= 0; i--) begin
      if (taken[i]) begin
        sel       = SEL_W'(i);
        any_taken = 1'b1;
      end
    end
    for (int i = 0; i < FETCH_W; i++)
      bus.slot_mask_o[i] = !any_taken || (SEL_W'(i) <= sel);
  end

  assign sel_type    = bus.btb_type_i[sel];
  assign ret_addr    = pc_q + PC_W'((32'(sel) + 32'd1) * INST_BYTES);
  assign redirect_hi = bus.commit_redirect_i || bus.excp_i || bus.recover_ex_i;
  assign front_ok    = !bus.stall_i && (state_q == RUN) && !bus.icache_miss_i;

  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    ras_d = ras_q;
    if (bus.commit_redirect_i) begin
      pc_d  = bus.commit_pc_i;
      ptr_d = '0;
    end else if (bus.excp_i) begin
      pc_d  = bus.excp_pc_i;
      ptr_d = '0;
    end else if (bus.recover_ex_i) begin
      pc_d  = bus.target_ex_i;
      ptr_d = bus.recover_ex_ckpt_i;
    end else if (front_ok) begin
      if (bus.recover_id_i) begin
        // Restore first, then apply the ID-detected call/return on top.
        pc_d  = bus.target_id_i;
        ptr_d = bus.recover_id_ckpt_i;
        if (bus.call_id_i) begin
          ptr_d        = bus.recover_id_ckpt_i + RP_W'(1);
          ras_d[ptr_d] = bus.call_pc_id_i;
        end else if (bus.rtr_id_i) begin
          pc_d  = ras_q[bus.recover_id_ckpt_i];
          ptr_d = bus.recover_id_ckpt_i - RP_W'(1);
        end
      end else if (any_taken) begin
        pc_d = (sel_type == 2'b00) ? ras_q[ptr_q] : bus.btb_target_i[sel];
        if (sel_type == 2'b01) begin
          ptr_d        = ptr_q + RP_W'(1);
          ras_d[ptr_d] = ret_addr;
        end else if (sel_type == 2'b00) begin
          ptr_d = ptr_q - RP_W'(1);
        end
      end else begin
        pc_d = pc_q + STRIDE;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    unique case (state_q)
      RUN: begin
        if (!redirect_hi && bus.icache_miss_i && !bus.stall_i) begin
          state_d     = MISS_REQ;
          miss_addr_d = pc_q;
        end
      end
      MISS_REQ:  state_d = redirect_hi ? RUN : MISS_WAIT;
      MISS_WAIT: if (redirect_hi || bus.fill_done_i) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  always_comb begin
    bus.valid_o    = 1'b0;
    bus.miss_req_o = 1'b0;
    unique case (state_q)
      RUN:      bus.valid_o    = !reset && !bus.icache_miss_i && !bus.stall_i;
      MISS_REQ: bus.miss_req_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      miss_addr_q <= '0;
      ptr_q       <= '0;
      ras_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      miss_addr_q <= miss_addr_d;
      ptr_q       <= ptr_d;
      ras_q       <= ras_d;
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.ras_ckpt_o  = ptr_q;
  assign bus.miss_addr_o = miss_addr_q;
endmodule

// File: tb/tb_fetch1_pc_gen.sv
// Directed bench for fetch1_pc_gen: sequential fetch, slot select, RAS, miss FSM, redirects.
module tb_fetch1_pc_gen;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fetch1_pc_gen_if #(.PC_W(32), .FETCH_W(4), .RAS_DEPTH(8)) bus ();

  fetch1_pc_gen #(
    .PC_W(32), .FETCH_W(4), .INST_BYTES(8), .RAS_DEPTH(8), .RESET_PC(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall_i = 0; bus.commit_redirect_i = 0; bus.commit_pc_i = 0;
    bus.excp_i = 0; bus.excp_pc_i = 0;
    bus.recover_ex_i = 0; bus.target_ex_i = 0; bus.recover_ex_ckpt_i = 0;
    bus.recover_id_i = 0; bus.target_id_i = 0; bus.recover_id_ckpt_i = 0;
    bus.call_id_i = 0; bus.call_pc_id_i = 0; bus.rtr_id_i = 0;
    bus.btb_hit_i = 0; bus.btb_type_i = 0; bus.btb_target_i = 0; bus.pred_i = 0;
    bus.icache_miss_i = 0; bus.fill_done_i = 0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.commit_redirect_i = 1; bus.commit_pc_i = pc;
    tick();
    clr();
  endtask

  logic [31:0] ret_q [9];
  logic [31:0] cur_pc;
  logic [31:0] tgt;

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr();
    reset = 1;
    tick();
    tick();
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_valid", 32'(bus.valid_o), 32'h0);
    chk("rst_miss_req", 32'(bus.miss_req_o), 32'h0);
    chk("rst_miss_addr", bus.miss_addr_o, 32'h0);
    chk("rst_mask", 32'(bus.slot_mask_o), 32'hF);
    chk("rst_ckpt", 32'(bus.ras_ckpt_o), 32'h0);

    // Sequential fetch
    reset = 0;
    #1;
    chk("seq_pc0", bus.pc_o, 32'h0);
    chk("seq_valid", 32'(bus.valid_o), 32'h1);
    tick();
    chk("seq_pc1", bus.pc_o, 32'h20);
    tick();
    chk("seq_pc2", bus.pc_o, 32'h40);

    // I-cache miss at 0x40
    bus.icache_miss_i = 1;
    #1;
    chk("miss_valid_run", 32'(bus.valid_o), 32'h0);
    tick();
    bus.icache_miss_i = 0;
    chk("miss_req_pulse", 32'(bus.miss_req_o), 32'h1);
    chk("miss_addr", bus.miss_addr_o, 32'h40);
    chk("miss_pc_hold0", bus.pc_o, 32'h40);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("miss_req_off", 32'(bus.miss_req_o), 32'h0);
      chk("miss_pc_hold", bus.pc_o, 32'h40);
      chk("miss_wait_valid", 32'(bus.valid_o), 32'h0);
    end
    bus.fill_done_i = 1;
    tick();
    bus.fill_done_i = 0;
    chk("refetch_pc", bus.pc_o, 32'h40);
    chk("refetch_valid", 32'(bus.valid_o), 32'h1);
    tick();
    chk("post_fill_pc", bus.pc_o, 32'h60);

    // Stall holds PC
    bus.stall_i = 1;
    #1;
    chk("stall_valid", 32'(bus.valid_o), 32'h0);
    tick();
    chk("stall_pc", bus.pc_o, 32'h60);
    bus.stall_i = 0;

    // Call in slot1, jump in slot2 also hit
    redirect(32'h100);
    chk("redir_pc", bus.pc_o, 32'h100);
    bus.btb_hit_i = 4'b0110;
    bus.btb_type_i[1] = 2'b01; bus.btb_target_i[1] = 32'h400;
    bus.btb_type_i[2] = 2'b10; bus.btb_target_i[2] = 32'h500;
    #1;
    chk("call_mask", 32'(bus.slot_mask_o), 32'h3);
    chk("call_ckpt", 32'(bus.ras_ckpt_o), 32'h0);
    tick();
    clr();
    chk("call_pc", bus.pc_o, 32'h400);
    chk("call_ptr", 32'(bus.ras_ckpt_o), 32'h1);
    bus.btb_hit_i = 4'b0001; bus.btb_type_i[0] = 2'b00;
    #1;
    chk("ret_mask", 32'(bus.slot_mask_o), 32'h1);
    tick();
    clr();
    chk("ret_pc", bus.pc_o, 32'h110);
    chk("ret_ptr", 32'(bus.ras_ckpt_o), 32'h0);

    // Not-predicted conditional in slot0, jump in slot3
    bus.btb_hit_i = 4'b1001;
    bus.btb_type_i[0] = 2'b11; bus.pred_i = 4'b0000; bus.btb_target_i[0] = 32'h700;
    bus.btb_type_i[3] = 2'b10; bus.btb_target_i[3] = 32'h800;
    #1;
    chk("cond_mask", 32'(bus.slot_mask_o), 32'hF);
    tick();
    clr();
    chk("cond_pc", bus.pc_o, 32'h800);

    // EX + ID recovery during MISS_WAIT
    bus.icache_miss_i = 1;
    tick();
    bus.icache_miss_i = 0;
    chk("miss2_addr", bus.miss_addr_o, 32'h800);
    tick();
    bus.recover_ex_i = 1; bus.target_ex_i = 32'h900; bus.recover_ex_ckpt_i = 3'd5;
    bus.recover_id_i = 1; bus.target_id_i = 32'hA00; bus.recover_id_ckpt_i = 3'd2;
    tick();
    clr();
    chk("ex_pc", bus.pc_o, 32'h900);
    chk("ex_ckpt", 32'(bus.ras_ckpt_o), 32'h5);
    chk("ex_valid", 32'(bus.valid_o), 32'h1);
    bus.fill_done_i = 1;
    tick();
    clr();
    chk("late_fill_pc", bus.pc_o, 32'h920);
    chk("late_fill_req", 32'(bus.miss_req_o), 32'h0);

    // ID recovery with a call push, then return to it
    bus.recover_id_i = 1; bus.target_id_i = 32'hB00; bus.recover_id_ckpt_i = 3'd3;
    bus.call_id_i = 1; bus.call_pc_id_i = 32'hC00;
    tick();
    clr();
    chk("id_call_pc", bus.pc_o, 32'hB00);
    chk("id_call_ptr", 32'(bus.ras_ckpt_o), 32'h4);
    bus.btb_hit_i = 4'b0001; bus.btb_type_i[0] = 2'b00;
    tick();
    clr();
    chk("id_ret_pc", bus.pc_o, 32'hC00);
    chk("id_ret_ptr", 32'(bus.ras_ckpt_o), 32'h3);

    // Exception overrides stall, clears RAS pointer
    bus.stall_i = 1; bus.excp_i = 1; bus.excp_pc_i = 32'h4000;
    tick();
    clr();
    chk("excp_pc", bus.pc_o, 32'h4000);
    chk("excp_ptr", 32'(bus.ras_ckpt_o), 32'h0);

    // Sequential PC wraps modulo 2^32
    redirect(32'hFFFF_FFE0);
    tick();
    chk("wrap_pc", bus.pc_o, 32'h0);

    // Nine calls, nine returns on an 8-deep RAS
    redirect(32'h2000);
    cur_pc = 32'h2000;
    for (int k = 0; k < 9; k++) begin
      tgt = 32'h3000 + 32'(k) * 32'h100;
      ret_q[k] = cur_pc + 32'h8;
      bus.btb_hit_i = 4'b0001; bus.btb_type_i[0] = 2'b01; bus.btb_target_i[0] = tgt;
      tick();
      clr();
      chk("call9_pc", bus.pc_o, tgt);
      cur_pc = tgt;
    end
    for (int k = 0; k < 9; k++) begin
      bus.btb_hit_i = 4'b0001; bus.btb_type_i[0] = 2'b00;
      tick();
      clr();
      chk("ret9_pc", bus.pc_o, (k < 8) ? ret_q[8 - k] : ret_q[8]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch1_pc_gen.md
Name: fetch1_pc_gen

Overview:
- Parametrised next-generation Fetch-1 PC generator.
- Owns the fetch PC register, the next-PC priority select across FETCH_W BTB/predictor slots, and an internal checkpointed return address stack (RAS).
- Adds an I-cache miss request/replay FSM and a taken-slot valid mask.
- Sits between the BTB/branch predictor/L1I outputs and the Fetch-2 pipeline register.

Parameters:
- PC_W, 32, PC width in bits.
- FETCH_W, 4, instructions per fetch bundle (power of 2, 1..8).
- INST_BYTES, 8, bytes per instruction.
- RAS_DEPTH, 8, RAS entries (power of 2); pointer width RP_W = log2(RAS_DEPTH).
- RESET_PC, 0, PC loaded at reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- stall_i  in  1  downstream stall; holds PC and RAS
- commit_redirect_i  in  1  commit-time recovery
- commit_pc_i  in  PC_W  commit-time recovery target
- excp_i  in  1  exception redirect
- excp_pc_i  in  PC_W  exception target
- recover_ex_i  in  1  EX-stage mispredict
- target_ex_i  in  PC_W  EX-stage redirect target
- recover_ex_ckpt_i  in  RP_W  RAS checkpoint to restore on EX recovery
- recover_id_i  in  1  ID-stage mispredict
- target_id_i  in  PC_W  ID-stage redirect target
- recover_id_ckpt_i  in  RP_W  RAS checkpoint to restore on ID recovery
- call_id_i  in  1  ID-detected call (BTB missed it)
- call_pc_id_i  in  PC_W  return address to push for call_id_i
- rtr_id_i  in  1  ID-detected return; target comes from RAS after restore
- btb_hit_i  in  FETCH_W  per-slot BTB hit
- btb_type_i  in  2*FETCH_W  per-slot type: 00 return, 01 call, 10 jump, 11 conditional
- btb_target_i  in  PC_W*FETCH_W  per-slot BTB target
- pred_i  in  FETCH_W  per-slot predicted direction
- icache_miss_i  in  1  L1I miss for current PC
- fill_done_i  in  1  miss fill complete
- pc_o  out  PC_W  current fetch PC
- valid_o  out  1  current bundle valid
- slot_mask_o  out  FETCH_W  valid slots up to and including the first taken slot
- ras_ckpt_o  out  RP_W  RAS top pointer sampled with this bundle
- miss_req_o  out  1  one-cycle miss request pulse
- miss_addr_o  out  PC_W  address of the outstanding miss

Behaviour:
- Reset values: PC=RESET_PC, FSM=RUN, RAS pointer=0, RAS entries=0, valid_o=0, miss_req_o=0, miss_addr_o=0, slot_mask_o all ones.
- Slot i is taken when btb_hit_i[i] and (type!=11 or pred_i[i]). sel = lowest taken slot.
- slot_mask_o has bits 0..sel set; all ones if no slot is taken. The mask is combinational.
- Slot target: RAS top if type==00, else btb_target_i[sel].
- Next-PC priority, highest first:
  - reset
  - commit_redirect_i
  - excp_i
  - recover_ex_i
  - recover_id_i (RAS top after restore if rtr_id_i, else target_id_i)
  - taken slot target
  - PC + FETCH_W*INST_BYTES, wrapping modulo 2^PC_W
- PC update: commit, exception and EX redirects apply regardless of stall or FSM state. ID redirect, slot target and sequential apply only when !stall_i and FSM==RUN and !icache_miss_i.
- FSM states:
  - RUN: valid_o = !icache_miss_i && !stall_i. On icache_miss_i && !stall_i with no redirect → MISS_REQ, PC held.
  - MISS_REQ: miss_req_o=1, miss_addr_o=PC latched; next cycle → MISS_WAIT.
  - MISS_WAIT: valid_o=0, PC held. fill_done_i → RUN, same PC refetched the next cycle.
  - Any commit, exception or EX redirect in MISS_REQ or MISS_WAIT → RUN at the new PC. A later fill_done_i is ignored.
- RAS behaviour:
  - Circular buffer indexed by the top pointer.
  - Push (slot call taken, RUN, !stall, no redirect): ptr+1, entry = PC + (sel+1)*INST_BYTES.
  - Pop (slot return taken): ptr-1.
  - Only one slot is selected, so push and pop never occur in the same cycle.
  - Overflow wraps and overwrites the oldest entry. Underflow wraps silently; the returned value is stale and is not flagged.
- RAS recovery:
  - EX recovery restores ptr = recover_ex_ckpt_i.
  - ID recovery restores ptr = recover_id_ckpt_i. Then call_id_i pushes call_pc_id_i, or rtr_id_i pops, in the same cycle.
  - Commit and exception redirects reset ptr to 0.
- ras_ckpt_o = ptr before this cycle's push or pop.

Test Plan:
- Reset, no hits, FETCH_W=4, INST_BYTES=8 → pc_o: 0, 0x20, 0x40 on successive cycles; valid_o=1; slot_mask_o=1111.
- PC=0x100, slot1 call (01) hit to 0x400, slot2 jump also hit → next pc_o=0x400; slot_mask_o=0011; RAS top=0x110. Later slot0 return hit → next PC=0x110; ptr back to its original value.
- Slot0 conditional hit with pred=0, slot3 jump to 0x800 → slot0 ignored; next PC=0x800; mask=1111.
- icache_miss_i at PC=0x40 → miss_req_o pulses 1 cycle with miss_addr_o=0x40; PC held for 5 cycles; fill_done_i → pc_o=0x40 with valid_o=1 the next cycle.
- recover_ex_i to 0x900 and recover_id_i in the same cycle while in MISS_WAIT → PC=0x900, FSM=RUN, RAS ptr=recover_ex_ckpt_i; a later fill_done_i has no effect.
- RAS_DEPTH=8: nine consecutive calls then nine returns → the first eight return targets are correct in LIFO order; the ninth returns the wrapped, overwritten entry.
